// File: rtl/elf_pkg.sv
// Shared types for the ELF RAM arbiter: grant owner encoding and FSM states.
package elf_pkg;

    localparam int OWNER_W = 2;

    typedef enum logic [OWNER_W-1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/elf_arb_prio.sv
// Combinational winner select for the ELF RAM arbiter.
// Loader always wins; DMA beats the CPU unless the CPU has starved.
module elf_arb_prio
    import elf_pkg::*;
(
    input  logic   ld_req,
    input  logic   dma_req,
    input  logic   cpu_req,
    input  logic   starve,
    output owner_e win
);

    // Fixed priority with a starvation override that lifts the CPU above DMA.
    always_comb begin
        win = OWN_NONE;
        if (ld_req) begin
            win = OWN_LD;
        end else if (cpu_req && starve) begin
            win = OWN_CPU;
        end else if (dma_req) begin
            win = OWN_DMA;
        end else if (cpu_req) begin
            win = OWN_CPU;
        end
    end

endmodule

// File: rtl/elf_ram_arbiter.sv
// Single-port RAM arbiter sharing one synchronous-read RAM between the HPS
// loader (writes), the CDP1861 video DMA (reads) and the CDP1802 CPU.
// One access at a time: IDLE picks a winner, ACCESS drives the RAM and acks,
// RDATA captures read data for the requester that owns the read.
// Optional feature macro: ELF_ROM_PROTECT_EN blocks CPU writes below ROM_TOP.
module elf_ram_arbiter
    import elf_pkg::*;
#(
    parameter int AW         = 12,
    parameter int STARVE_MAX = 8,
    parameter int ROM_TOP    = 'h200
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ack,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [7:0]    dma_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [1:0]    owner
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state;
    arb_state_e    state_nxt;
    owner_e        win;
    owner_e        own_p1;      // requester owning the access in flight
    logic          rd_p1;       // access in flight is a read
    logic [SW-1:0] starve_cnt;
    logic          starve;
    logic          cpu_prot;    // CPU write lands in the protected low region

    assign starve = (starve_cnt == SW'(STARVE_MAX));
    assign owner  = own_p1;

`ifdef ELF_ROM_PROTECT_EN
    assign cpu_prot = (int'(cpu_addr) < ROM_TOP);
`else
    logic rom_top_unused;
    assign rom_top_unused = (ROM_TOP == 0);
    assign cpu_prot       = 1'b0;
`endif

    elf_arb_prio u_prio (
        .ld_req  (ld_req),
        .dma_req (dma_req),
        .cpu_req (cpu_req),
        .starve  (starve),
        .win     (win)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: writes take two cycles, reads add the RDATA capture cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win != OWN_NONE) state_nxt = ACCESS;
            ACCESS:  state_nxt = rd_p1 ? RDATA : IDLE;
            RDATA:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Launch: latch the winner's address/data into the RAM port and pulse its ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_ack    <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_p1     <= 1'b0;
            own_p1    <= OWN_NONE;
        end else begin
            ld_ack  <= 1'b0;
            dma_ack <= 1'b0;
            cpu_ack <= 1'b0;
            mem_we  <= 1'b0;
            unique case (state)
                IDLE: begin
                    own_p1 <= win;
                    unique case (win)
                        OWN_LD: begin
                            mem_addr  <= ld_addr;
                            mem_wdata <= ld_data;
                            mem_we    <= 1'b1;
                            rd_p1     <= 1'b0;
                            ld_ack    <= 1'b1;
                        end
                        OWN_DMA: begin
                            mem_addr <= dma_addr;
                            rd_p1    <= 1'b1;
                            dma_ack  <= 1'b1;
                        end
                        OWN_CPU: begin
                            mem_addr <= cpu_addr;
                            rd_p1    <= ~cpu_we;
                            cpu_ack  <= 1'b1;
                            if (cpu_we) begin
                                mem_wdata <= cpu_wdata;
                                mem_we    <= ~cpu_prot;
                            end
                        end
                        default: begin
                            rd_p1 <= 1'b0;
                        end
                    endcase
                end
                ACCESS: begin
                    if (!rd_p1) own_p1 <= OWN_NONE;
                end
                RDATA: begin
                    own_p1 <= OWN_NONE;
                end
                default: begin
                    own_p1 <= OWN_NONE;
                end
            endcase
        end
    end

    // Read return: steer captured RAM data only to the requester that owns the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            dma_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            if (state == RDATA) begin
                if (own_p1 == OWN_DMA) begin
                    dma_rdata  <= mem_rdata;
                    dma_rvalid <= 1'b1;
                end else if (own_p1 == OWN_CPU) begin
                    cpu_rdata  <= mem_rdata;
                    cpu_rvalid <= 1'b1;
                end
            end
        end
    end

    // Starvation counter: counts CPU wait cycles, cleared once granted or idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!cpu_req || cpu_ack || (state == IDLE && win == OWN_CPU)) begin
            starve_cnt <= '0;
        end else if (!starve) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_elf_ram_arbiter.sv
// Directed bench for elf_ram_arbiter with a behavioural synchronous-read RAM.
module tb_elf_ram_arbiter;

    localparam int AW         = 12;
    localparam int STARVE_MAX = 8;

`ifdef ELF_ROM_PROTECT_EN
    localparam logic       EXP_ROM_WE = 1'b0;
    localparam logic [7:0] EXP_ROM_RD = 8'h3C;
`else
    localparam logic       EXP_ROM_WE = 1'b1;
    localparam logic [7:0] EXP_ROM_RD = 8'hFF;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = '0;
    logic          ld_ack;
    logic          dma_req = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic          dma_ack;
    logic          dma_rvalid;
    logic [7:0]    dma_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [7:0]    cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [1:0]    owner;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ram [0:(1<<AW)-1];

    elf_ram_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX), .ROM_TOP('h200)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ack     (ld_ack),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_ack    (dma_ack),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [43:0] out_bus();
        return {ld_ack, dma_ack, dma_rvalid, dma_rdata, cpu_ack, cpu_rvalid,
                cpu_rdata, mem_addr, mem_we, mem_wdata, owner};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        idle(3);
        n_tests++;
        if (out_bus() !== 44'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", out_bus());
        end
        n_tests++;
        if (dut.starve_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt);
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_cpu_rw();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'h5A;
        tick();
        n_tests++;
        if ({cpu_ack, mem_we, mem_addr, mem_wdata, owner} !== {1'b1, 1'b1, 12'h300, 8'h5A, 2'd3}) begin
            n_fail++;
            $display("FAIL cpu_wr_access: ack=%b we=%b addr=%h wd=%h own=%0d want 1 1 300 5a 3",
                     cpu_ack, mem_we, mem_addr, mem_wdata, owner);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        n_tests++;
        if ({cpu_ack, mem_we, owner} !== 4'b0000) begin
            n_fail++;
            $display("FAIL cpu_wr_done: ack=%b we=%b own=%0d want 0 0 0", cpu_ack, mem_we, owner);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
        tick();
        n_tests++;
        if ({cpu_ack, mem_we, owner} !== {1'b1, 1'b0, 2'd3}) begin
            n_fail++;
            $display("FAIL cpu_rd_access: ack=%b we=%b own=%0d want 1 0 3", cpu_ack, mem_we, owner);
        end
        cpu_req = 1'b0;
        tick();
        n_tests++;
        if ({cpu_ack, cpu_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL cpu_rd_rdata_cycle: ack=%b rvalid=%b want 0 0", cpu_ack, cpu_rvalid);
        end
        tick();
        n_tests++;
        if ({cpu_rvalid, cpu_rdata, owner} !== {1'b1, 8'h5A, 2'd0}) begin
            n_fail++;
            $display("FAIL cpu_rd_data: rvalid=%b rdata=%h own=%0d want 1 5a 0", cpu_rvalid, cpu_rdata, owner);
        end
        tick();
        n_tests++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'h5A}) begin
            n_fail++;
            $display("FAIL cpu_rd_hold: rvalid=%b rdata=%h want 0 5a", cpu_rvalid, cpu_rdata);
        end
        idle(1);
    endtask

    task automatic test_priority();
        int ld_c = -1, dma_c = -1, cpu_c = -1, dv_c = -1, cv_c = -1, dbl = 0;
        logic [7:0] dv = '0, cv = '0;
        ld_req = 1'b1;  ld_addr = 12'h020; ld_data = 8'hA5;
        dma_req = 1'b1; dma_addr = 12'h020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if ((32'(ld_ack) + 32'(dma_ack) + 32'(cpu_ack)) > 1) dbl++;
            if (ld_ack  && ld_c  < 0) begin ld_c  = c; ld_req  = 1'b0; end
            if (dma_ack && dma_c < 0) begin dma_c = c; dma_req = 1'b0; end
            if (cpu_ack && cpu_c < 0) begin cpu_c = c; cpu_req = 1'b0; end
            if (dma_rvalid && dv_c < 0) begin dv_c = c; dv = dma_rdata; end
            if (cpu_rvalid && cv_c < 0) begin cv_c = c; cv = cpu_rdata; end
        end
        ld_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
        n_tests++;
        if (dbl != 0) begin
            n_fail++;
            $display("FAIL prio_double_ack: got %0d cycles with >1 ack want 0", dbl);
        end
        n_tests++;
        if (ld_c != 1 || dma_c != 3 || cpu_c != 6) begin
            n_fail++;
            $display("FAIL prio_order: ld=%0d dma=%0d cpu=%0d want 1 3 6", ld_c, dma_c, cpu_c);
        end
        n_tests++;
        if (dv_c != 5 || dv !== 8'hA5) begin
            n_fail++;
            $display("FAIL prio_dma_read: cyc=%0d data=%h want 5 a5", dv_c, dv);
        end
        n_tests++;
        if (cv_c != 8 || cv !== 8'h5A) begin
            n_fail++;
            $display("FAIL prio_cpu_read: cyc=%0d data=%h want 8 5a", cv_c, cv);
        end
        idle(1);
    endtask

    task automatic test_starve();
        int dma_n = 0, cpu_c = -1, max_cnt = 0, cnt_at_ack = -1;
        dma_req = 1'b1; dma_addr = 12'h020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (int'(dut.starve_cnt) > max_cnt) max_cnt = int'(dut.starve_cnt);
            if (dma_ack && cpu_c < 0) dma_n++;
            if (cpu_ack && cpu_c < 0) begin
                cpu_c = c;
                cnt_at_ack = int'(dut.starve_cnt);
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end
        end
        n_tests++;
        if (cpu_c != 10 || dma_n != 3) begin
            n_fail++;
            $display("FAIL starve_grant: cpu_ack cyc=%0d dma_acks=%0d want 10 3", cpu_c, dma_n);
        end
        n_tests++;
        if (max_cnt != STARVE_MAX) begin
            n_fail++;
            $display("FAIL starve_peak: got %0d want %0d", max_cnt, STARVE_MAX);
        end
        n_tests++;
        if (cnt_at_ack != 0 || dut.starve_cnt !== '0) begin
            n_fail++;
            $display("FAIL starve_clear: at_ack=%0d end=%0d want 0 0", cnt_at_ack, dut.starve_cnt);
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        idle(1);
    endtask

    task automatic test_reset_mid();
        int rv = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
        tick();
        n_tests++;
        if (cpu_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ack: got %b want 1", cpu_ack);
        end
        cpu_req = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (out_bus() !== 44'd0 || dut.state !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h state=%0d want 0 0", out_bus(), dut.state);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (cpu_rvalid) rv++;
        end
        n_tests++;
        if (rv != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_rvalid: got %0d pulses want 0", rv);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL rstmid_recover: rvalid=%b rdata=%h want 1 5a", cpu_rvalid, cpu_rdata);
        end
        idle(1);
    endtask

    task automatic test_rom_protect();
        ld_req = 1'b1; ld_addr = 12'h010; ld_data = 8'h3C;
        tick();
        ld_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'hFF;
        tick();
        n_tests++;
        if ({cpu_ack, mem_we} !== {1'b1, EXP_ROM_WE}) begin
            n_fail++;
            $display("FAIL rom_write: ack=%b we=%b want 1 %b", cpu_ack, mem_we, EXP_ROM_WE);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_addr = 12'h010;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, EXP_ROM_RD}) begin
            n_fail++;
            $display("FAIL rom_readback: rvalid=%b rdata=%h want 1 %h", cpu_rvalid, cpu_rdata, EXP_ROM_RD);
        end
        idle(1);
    endtask

    task automatic test_ld_stream();
        int bad_gap = 0, bad_mem = 0, c;
        ld_req = 1'b1; ld_addr = 12'h000; ld_data = 8'h00 ^ 8'hC3;
        for (int i = 0; i < 256; i++) begin
            c = 0;
            do begin
                tick();
                c++;
            end while (!ld_ack && c < 8);
            if (!ld_ack || c != 1) bad_gap++;
            tick();
            if (i == 255) begin
                ld_req = 1'b0;
            end else begin
                ld_addr = 12'(i + 1);
                ld_data = 8'(i + 1) ^ 8'hC3;
            end
        end
        idle(2);
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== (8'(i) ^ 8'hC3)) bad_mem++;
        end
        n_tests++;
        if (bad_gap != 0) begin
            n_fail++;
            $display("FAIL ld_stream_rate: %0d acks off the 2-cycle cadence, want 0", bad_gap);
        end
        n_tests++;
        if (bad_mem != 0) begin
            n_fail++;
            $display("FAIL ld_stream_ram: %0d bytes wrong (ram[0]=%h ram[255]=%h) want 0", bad_mem, ram[0], ram[255]);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_priority();
        test_starve();
        test_reset_mid();
        test_rom_protect();
        test_ld_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
